// File: rtl/pb_gesture_pkg.sv
// Shared definitions for the push-button gesture decoder.
// Contents: FSM state encoding, default tick constants and a helper that
// sizes the interval counter from the tick values.
package pb_gesture_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    HOLD   = 3'd4
  } state_e;

  localparam int unsigned DEF_LONG_TICKS   = 12_000_000;
  localparam int unsigned DEF_DBL_TICKS    = 6_000_000;
  localparam int unsigned DEF_REPEAT_TICKS = 3_000_000;

  // Bits needed to hold the largest of the three intervals.
  function automatic int unsigned cnt_width(input int unsigned long_t,
                                            input int unsigned dbl_t,
                                            input int unsigned rep_t);
    int unsigned m;
    m = long_t;
    if (dbl_t > m) m = dbl_t;
    if (rep_t > m) m = rep_t;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pb_gesture_decoder.sv
// Push-button gesture decoder: classifies debounced press/release events
// into short click, double click, long press and auto-repeat pulses.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   PB_state        - debounced level, 1 while pressed
//   PB_down, PB_up  - one-cycle press / release events
//   click_short     - one-cycle pulse, single short click
//   click_double    - one-cycle pulse, double click
//   press_long      - one-cycle pulse, long-press threshold reached
//   press_repeat    - one-cycle pulse every REPEAT_TICKS while held long
//   busy            - 1 whenever a gesture is in progress
module pb_gesture_decoder
  import pb_gesture_pkg::*;
#(
  parameter int unsigned LONG_TICKS   = DEF_LONG_TICKS,
  parameter int unsigned DBL_TICKS    = DEF_DBL_TICKS,
  parameter int unsigned REPEAT_TICKS = DEF_REPEAT_TICKS,
  parameter int unsigned CNT_W        = cnt_width(LONG_TICKS, DBL_TICKS, REPEAT_TICKS)
) (
  input  logic clk,
  input  logic reset,
  input  logic PB_state,
  input  logic PB_down,
  input  logic PB_up,
  output logic click_short,
  output logic click_double,
  output logic press_long,
  output logic press_repeat,
  output logic busy
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_TICKS - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic short_q, short_d, double_q, double_d;
  logic long_q, long_d, repeat_q, repeat_d, busy_q, busy_d;
  logic both_ev, dn_ev, rel_ev;

  // Simultaneous press and release is illegal upstream: drop the whole cycle.
  // A low level without a release event is treated as a missed release.
  assign both_ev = PB_down & PB_up;
  assign dn_ev   = PB_down & ~both_ev;
  assign rel_ev  = ~both_ev & (PB_up | ~PB_state);

  // Saturating increment, never wraps.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state, counter and pulse decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (dn_ev) state_d = PRESS1;
      end
      PRESS1: begin
        cnt_d = cnt_inc;
        if (rel_ev) begin
          state_d = WAIT2;
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = HOLD;
        end
      end
      WAIT2: begin
        cnt_d = cnt_inc;
        if (dn_ev) begin
          state_d = PRESS2;
        end else if (cnt_q == DBL_LAST) begin
          short_d = 1'b1;
          state_d = IDLE;
        end
      end
      PRESS2: begin
        if (rel_ev) begin
          double_d = 1'b1;
          state_d  = IDLE;
        end
      end
      HOLD: begin
        cnt_d = cnt_inc;
        if (rel_ev) begin
          state_d = IDLE;
        end else if (cnt_q == REP_LAST) begin
          repeat_d = 1'b1;
          cnt_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Every state entry starts a fresh interval.
    if (state_d != state_q) cnt_d = '0;
    busy_d = (state_d != IDLE);
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      double_q <= double_d;
      long_q   <= long_d;
      repeat_q <= repeat_d;
      busy_q   <= busy_d;
    end
  end

  assign click_short  = short_q;
  assign click_double = double_q;
  assign press_long   = long_q;
  assign press_repeat = repeat_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_pb_gesture_decoder.sv
// Directed bench for pb_gesture_decoder with small tick values.
// Cycle c denotes posedge c; outputs "at cN" are the values visible just
// before posedge N, sampled on the preceding negedge.
module tb_pb_gesture_decoder;

  logic clk = 1'b0;
  logic reset, PB_state, PB_down, PB_up;
  logic click_short, click_double, press_long, press_repeat, busy;

  int n_checks = 0;
  int n_errors = 0;

  pb_gesture_decoder #(
    .LONG_TICKS  (8),
    .DBL_TICKS   (6),
    .REPEAT_TICKS(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .PB_state    (PB_state),
    .PB_down     (PB_down),
    .PB_up       (PB_up),
    .click_short (click_short),
    .click_double(click_double),
    .press_long  (press_long),
    .press_repeat(press_repeat),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (short,double,long,repeat,busy)", tag, got, exp);
    end
  endtask

  // Inputs for test t at cycle c: {reset, PB_state, PB_down, PB_up}.
  function automatic logic [3:0] stim(input int t, input int c);
    logic r, s, d, u;
    r = 1'b0; s = 1'b0; d = 1'b0; u = 1'b0;
    case (t)
      1: begin d = (c == 0); u = (c == 3); s = (c < 3); end
      2: begin d = (c == 0 || c == 6); u = (c == 3 || c == 10);
               s = (c < 3) || (c >= 6 && c < 10); end
      3: begin d = (c == 0); u = (c == 20); s = (c < 20); end
      4: begin d = (c == 0); u = (c == 8); s = (c < 8); end
      5: begin d = (c == 0 || c == 9); u = (c == 3 || c == 12);
               s = (c < 3) || (c >= 9 && c < 12); end
      6: begin d = (c == 0); u = (c == 7); s = (c < 7); r = (c == 4 || c == 5); end
      7: begin d = (c == 0); s = (c < 3); end
      8: begin d = (c == 0); u = (c == 0); end
      default: ;
    endcase
    return {r, s, d, u};
  endfunction

  // Expected {short, double, long, repeat, busy} for test t at cycle c.
  function automatic logic [4:0] expect_out(input int t, input int c);
    logic sh, db, lg, rp, bz;
    sh = 1'b0; db = 1'b0; lg = 1'b0; rp = 1'b0; bz = 1'b0;
    case (t)
      1: begin sh = (c == 10); bz = (c >= 1 && c <= 9);  end
      2: begin db = (c == 11); bz = (c >= 1 && c <= 10); end
      3: begin lg = (c == 9); rp = (c == 13 || c == 17); bz = (c >= 1 && c <= 20); end
      4: begin sh = (c == 15); bz = (c >= 1 && c <= 14); end
      5: begin db = (c == 13); bz = (c >= 1 && c <= 12); end
      6: begin bz = (c >= 1 && c <= 4); end
      7: begin sh = (c == 10); bz = (c >= 1 && c <= 9);  end
      default: ;
    endcase
    return {sh, db, lg, rp, bz};
  endfunction

  task automatic run_test(input int t, input int len);
    logic [3:0] s;
    logic [4:0] got;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      got = {click_short, click_double, press_long, press_repeat, busy};
      check($sformatf("t%0d c%0d", t, c), got, expect_out(t, c));
      check($sformatf("t%0d c%0d onehot", t, c), {4'b0, $onehot0(got[4:1])}, 5'd1);
      s = stim(t, c);
      {reset, PB_state, PB_down, PB_up} = s;
    end
    @(negedge clk);
    {reset, PB_state, PB_down, PB_up} = 4'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; PB_state = 1'b0; PB_down = 1'b0; PB_up = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset", {click_short, click_double, press_long, press_repeat, busy}, 5'b0);
    reset = 1'b0;
    run_test(1, 14);
    run_test(2, 15);
    run_test(3, 24);
    run_test(4, 18);
    run_test(5, 16);
    run_test(6, 12);
    run_test(7, 14);
    run_test(8, 5);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
